systolic_array_ctrl: RTL and testbench
======================================

// Module: systolic_array_ctrl
// PURPOSE
//  Sequencer for one systolic_array instance: buffers two NxN operand matrices loaded row by row.
//  Clears the array, then streams A columns and B rows into it over N cycles.
//  Captures the N result rows of C = A*B and drains them to a downstream consumer with valid/ready.
//  Sits between the host-side load/unload interfaces and the array's port-level interface.
// PARAMETERS
//  DATAWIDTH  16    operand element width (signed); result element width = 2*DATAWIDTH
//  N_SIZE     3     matrix dimension N (N >= 2)
//  TIMEOUT    64    max cycles in WAIT before abort
// PORTS
//  clk          in   1               clock, all logic on rising edge
//  rst          in   1               synchronous active-high reset
//  in_valid     in   1               load beat valid
//  in_ready     out  1               load beat accepted when in_valid & in_ready
//  in_a_row     in   N*DATAWIDTH     row i of A, element j at bits [j*DW +: DW]
//  in_b_row     in   N*DATAWIDTH     row i of B, same packing
//  sa_rst_n     out  1               array reset (active-low), registered
//  sa_valid_in  out  1               to array valid_in, registered
//  sa_matrix_a  out  N*DATAWIDTH     A column k, element i (row) at slice i
//  sa_matrix_b  out  N*DATAWIDTH     B row k, element j at slice j
//  sa_valid_out in   1               from array valid_out
//  sa_matrix_c  in   N*2*DATAWIDTH   from array: one C row, element j at slice j
//  out_valid    out  1               result row valid
//  out_ready    in   1               consumer accepts row when out_valid & out_ready
//  out_row      out  N*2*DATAWIDTH   C row r, element j at slice j
//  out_last     out  1               high with row N-1
//  busy         out  1               high in any state except LOAD
//  done         out  1               1-cycle pulse after final row handshake
//  err          out  1               sticky timeout flag; cleared on next accepted load beat
// BEHAVIOUR
//  Reset: state=LOAD, counters=0, in_ready=1, sa_rst_n=1, sa_valid_in=0, sa data=0,
//   out_valid=0, out_last=0, done=0, err=0, busy=0. Buffers need not clear.
//  LOAD: in_ready=1. Beat i writes A[i][*] and B[i][*]. On Nth accept -> CLR; in_ready=0 next cycle.
//  CLR: one cycle; sa_rst_n=0 during it. Clears array accumulators between jobs. -> FEED.
//  FEED: N consecutive cycles, k=0..N-1.
//   sa_valid_in=1; sa_matrix_a slice i = A[i][k]; sa_matrix_b slice j = B[k][j].
//   After k=N-1: sa_valid_in=0, sa data=0 -> WAIT.
//  WAIT: each cycle with sa_valid_out=1 stores sa_matrix_c as C row r, r++.
//   Rows need not be contiguous. r==N -> DRAIN.
//   sa_valid_out outside WAIT is ignored.
//   Cycle counter starts at 0 on entry; reaching TIMEOUT with r<N: err=1, C discarded -> LOAD (no done).
//  DRAIN: out_valid=1 with C row r (r=0..N-1), out_last=(r==N-1).
//   Row held stable while out_ready=0; advances on handshake.
//   After row N-1 handshake: done=1 next cycle, out_valid=0 -> LOAD.
//  No new load while busy: in_ready=0 in CLR/FEED/WAIT/DRAIN.
//  Result elements are captured verbatim (2*DW signed); the controller does no arithmetic.
//  rst mid-operation (any state): next cycle equals reset state; partial A/B/C abandoned.
//   sa_rst_n stays 1; the next job's CLR clears the array.
//  Min latency, last load beat to first out_valid: 1(CLR)+N(FEED)+array latency+1.
// TESTING
//  A=[1 2 3;4 5 6;7 8 9], B=[9 8 7;6 5 4;3 2 1], out_ready=1
//   -> rows [30,24,18],[84,69,54],[138,114,90]; out_last on row 2; one done pulse.
//  Back-to-back job A=[2 3 4;5 6 7;8 9 10], B=[1 2 3;4 5 6;7 8 9]
//   -> CLR pulse seen; rows [42,51,60],[78,96,114],[114,141,168]; no carry-over from job 1.
//  Job 1 with out_ready toggled 0/1 every 2 cycles -> out_row stable while stalled; 3 handshakes; done after the last.
//  Array stub never asserts sa_valid_out -> err=1 exactly TIMEOUT cycles after WAIT entry; no out_valid; in_ready=1.
//   err clears on next load beat.
//  rst asserted for 1 cycle during FEED k=1 -> all outputs at reset values next cycle;
//   full new job then yields correct C.
//  in_valid held high during busy -> no beats accepted (in_ready=0); buffered A/B unchanged (C correct).

Source files
------------

// File: rtl/systolic_array_ctrl.sv
//------------------------------------------------------------------------------
// systolic_array_ctrl
//
// Sequencer for one systolic array instance. It buffers two NxN operand
// matrices loaded one row per beat, clears the array, and then streams them
// into the array over N cycles. On cycle k the array receives column k of A
// and row k of B, so the array accumulates the outer products that sum to
// C = A*B. The controller then captures the N result rows the array returns
// and drains them to a downstream consumer with a valid/ready handshake.
//
// Ports
//   clk          in   1             clock, all logic on the rising edge
//   rst          in   1             synchronous active-high reset
//   in_valid     in   1             load beat valid
//   in_ready     out  1             load beat accepted when in_valid & in_ready
//   in_a_row     in   N*DW          row i of A, element j at [j*DW +: DW]
//   in_b_row     in   N*DW          row i of B, same packing
//   sa_rst_n     out  1             array reset (active-low), registered
//   sa_valid_in  out  1             array valid_in, registered
//   sa_matrix_a  out  N*DW          A column k, element i at slice i
//   sa_matrix_b  out  N*DW          B row k, element j at slice j
//   sa_valid_out in   1             array valid_out
//   sa_matrix_c  in   N*2*DW        one C row from the array, element j at slice j
//   out_valid    out  1             result row valid
//   out_ready    in   1             consumer accepts row when out_valid & out_ready
//   out_row      out  N*2*DW        C row r, element j at slice j
//   out_last     out  1             high with row N-1
//   busy         out  1             high in every state except LOAD
//   done         out  1             one-cycle pulse after the final row handshake
//   err          out  1             sticky timeout flag, cleared by the next load beat
//------------------------------------------------------------------------------
module systolic_array_ctrl #(
   parameter int DATAWIDTH = 16,
   parameter int N_SIZE    = 3,
   parameter int TIMEOUT   = 64
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            in_valid,
   output logic                            in_ready,
   input  logic [N_SIZE*DATAWIDTH-1:0]     in_a_row,
   input  logic [N_SIZE*DATAWIDTH-1:0]     in_b_row,
   output logic                            sa_rst_n,
   output logic                            sa_valid_in,
   output logic [N_SIZE*DATAWIDTH-1:0]     sa_matrix_a,
   output logic [N_SIZE*DATAWIDTH-1:0]     sa_matrix_b,
   input  logic                            sa_valid_out,
   input  logic [N_SIZE*2*DATAWIDTH-1:0]   sa_matrix_c,
   output logic                            out_valid,
   input  logic                            out_ready,
   output logic [N_SIZE*2*DATAWIDTH-1:0]   out_row,
   output logic                            out_last,
   output logic                            busy,
   output logic                            done,
   output logic                            err
);

   localparam int AW = N_SIZE * DATAWIDTH;
   localparam int CW = N_SIZE * 2 * DATAWIDTH;

   // One index counter serves every phase (load beat, feed step, captured
   // row, drained row); it only ever needs to reach N-1 because each phase
   // resets it when it hands over to the next.
   localparam int IW = (N_SIZE > 1) ? $clog2(N_SIZE) : 1;
   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   localparam logic [IW-1:0] IDX_LAST = IW'(N_SIZE - 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      ST_LOAD,
      ST_CLR,
      ST_FEED,
      ST_WAIT,
      ST_DRAIN
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [IW-1:0]    r_idx;
   logic [IW-1:0]    w_idx_nxt;
   logic [TW-1:0]    r_tmo;
   logic [TW-1:0]    w_tmo_nxt;

   logic             w_load_acc;
   logic             w_c_wr;
   logic             w_timeout;
   logic             w_out_hs;
   logic             w_done_nxt;

   logic             r_sa_rst_n;
   logic             r_sa_valid_in;
   logic [AW-1:0]    r_sa_a;
   logic [AW-1:0]    r_sa_b;
   logic [AW-1:0]    w_sa_a_nxt;
   logic [AW-1:0]    w_sa_b_nxt;
   logic             r_done;
   logic             r_err;

   // Row-indexed operand and result buffers.
   logic [AW-1:0]    r_a_buf [N_SIZE];
   logic [AW-1:0]    r_b_buf [N_SIZE];
   logic [CW-1:0]    r_c_buf [N_SIZE];

   //---------------------------------------------------------------------------
   // Next-state logic
   //---------------------------------------------------------------------------
   // NOTE: every signal written here gets a default first, so no path through
   // the case leaves a value unassigned and no latch is inferred.
   always_comb begin
      w_state_nxt = r_state;
      w_idx_nxt   = r_idx;
      w_tmo_nxt   = r_tmo;
      w_load_acc  = 1'b0;
      w_c_wr      = 1'b0;
      w_timeout   = 1'b0;
      w_out_hs    = 1'b0;

      case (r_state)
         ST_LOAD: begin
            if (in_valid) begin
               w_load_acc = 1'b1;
               if (r_idx == IDX_LAST) begin
                  w_state_nxt = ST_CLR;
                  w_idx_nxt   = '0;
               end else begin
                  w_idx_nxt = r_idx + IW'(1);
               end
            end
         end

         ST_CLR: begin
            w_state_nxt = ST_FEED;
            w_idx_nxt   = '0;
         end

         ST_FEED: begin
            if (r_idx == IDX_LAST) begin
               w_state_nxt = ST_WAIT;
               w_idx_nxt   = '0;
               w_tmo_nxt   = '0;
            end else begin
               w_idx_nxt = r_idx + IW'(1);
            end
         end

         ST_WAIT: begin
            if (sa_valid_out) begin
               w_c_wr = 1'b1;
               if (r_idx == IDX_LAST) begin
                  w_state_nxt = ST_DRAIN;
                  w_idx_nxt   = '0;
               end else begin
                  w_idx_nxt = r_idx + IW'(1);
               end
            end
            // A row arriving on the final allowed cycle still completes the job.
            if (w_state_nxt == ST_WAIT) begin
               if (r_tmo == TMO_LAST) begin
                  w_timeout   = 1'b1;
                  w_state_nxt = ST_LOAD;
                  w_idx_nxt   = '0;
               end else begin
                  w_tmo_nxt = r_tmo + TW'(1);
               end
            end
         end

         ST_DRAIN: begin
            if (out_ready) begin
               w_out_hs = 1'b1;
               if (r_idx == IDX_LAST) begin
                  w_state_nxt = ST_LOAD;
                  w_idx_nxt   = '0;
               end else begin
                  w_idx_nxt = r_idx + IW'(1);
               end
            end
         end

         default: begin
            w_state_nxt = ST_LOAD;
            w_idx_nxt   = '0;
         end
      endcase
   end

   assign w_done_nxt = w_out_hs && (r_idx == IDX_LAST);

   // Array-side outputs are registered, so they are computed from the next
   // state: while in FEED step k the array sees column k of A and row k of B.
   always_comb begin
      w_sa_a_nxt = '0;
      w_sa_b_nxt = '0;
      if (w_state_nxt == ST_FEED) begin
         for (int i = 0; i < N_SIZE; i++) begin
            w_sa_a_nxt[i*DATAWIDTH +: DATAWIDTH] =
               r_a_buf[i][int'(w_idx_nxt)*DATAWIDTH +: DATAWIDTH];
         end
         w_sa_b_nxt = r_b_buf[w_idx_nxt];
      end
   end

   //---------------------------------------------------------------------------
   // State and control registers
   //---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= ST_LOAD;
         r_idx         <= '0;
         r_tmo         <= '0;
         r_sa_rst_n    <= 1'b1;
         r_sa_valid_in <= 1'b0;
         r_sa_a        <= '0;
         r_sa_b        <= '0;
         r_done        <= 1'b0;
         r_err         <= 1'b0;
      end else begin
         r_state       <= w_state_nxt;
         r_idx         <= w_idx_nxt;
         r_tmo         <= w_tmo_nxt;
         r_sa_rst_n    <= (w_state_nxt != ST_CLR);
         r_sa_valid_in <= (w_state_nxt == ST_FEED);
         r_sa_a        <= w_sa_a_nxt;
         r_sa_b        <= w_sa_b_nxt;
         r_done        <= w_done_nxt;
         if (w_load_acc) begin
            r_err <= 1'b0;
         end else if (w_timeout) begin
            r_err <= 1'b1;
         end
      end
   end

   // NOTE: the data buffers are deliberately left out of reset; every entry
   // is written before it is read in each job, so a reset would only cost
   // routing and fan-out on rst.
   always_ff @(posedge clk) begin
      if (w_load_acc) begin
         r_a_buf[r_idx] <= in_a_row;
         r_b_buf[r_idx] <= in_b_row;
      end
      if (w_c_wr) begin
         r_c_buf[r_idx] <= sa_matrix_c;
      end
   end

   //---------------------------------------------------------------------------
   // Outputs
   //---------------------------------------------------------------------------
   assign in_ready    = (r_state == ST_LOAD);
   assign busy        = (r_state != ST_LOAD);
   assign sa_rst_n    = r_sa_rst_n;
   assign sa_valid_in = r_sa_valid_in;
   assign sa_matrix_a = r_sa_a;
   assign sa_matrix_b = r_sa_b;
   assign out_valid   = (r_state == ST_DRAIN);
   assign out_row     = out_valid ? r_c_buf[r_idx] : '0;
   assign out_last    = out_valid && (r_idx == IDX_LAST);
   assign done        = r_done;
   assign err         = r_err;

endmodule

// File: tb/tb_systolic_array_ctrl.sv
//------------------------------------------------------------------------------
// tb_systolic_array_ctrl
//
// Self-checking bench for systolic_array_ctrl. A behavioural array stub
// accumulates outer products of whatever the controller feeds it and returns
// the result rows after a random latency with random gaps; expected results
// come from a plain matrix multiply of the loaded operands.
//------------------------------------------------------------------------------
module tb_systolic_array_ctrl;

   localparam int DW  = 16;
   localparam int N   = 3;
   localparam int TMO = 64;
   localparam int AW  = N * DW;
   localparam int CW  = N * 2 * DW;

   typedef int mat_t [N][N];

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [AW-1:0] in_a_row;
   logic [AW-1:0] in_b_row;
   logic          sa_rst_n;
   logic          sa_valid_in;
   logic [AW-1:0] sa_matrix_a;
   logic [AW-1:0] sa_matrix_b;
   logic          sa_valid_out = 1'b0;
   logic [CW-1:0] sa_matrix_c  = '0;
   logic          out_valid;
   logic          out_ready;
   logic [CW-1:0] out_row;
   logic          out_last;
   logic          busy;
   logic          done;
   logic          err;

   int n_checks = 0;
   int n_fail   = 0;

   bit stub_mute  = 1'b0;
   bit stub_noise = 1'b1;

   always #5 clk = ~clk;

   systolic_array_ctrl #(
      .DATAWIDTH (DW),
      .N_SIZE    (N),
      .TIMEOUT   (TMO)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_a_row     (in_a_row),
      .in_b_row     (in_b_row),
      .sa_rst_n     (sa_rst_n),
      .sa_valid_in  (sa_valid_in),
      .sa_matrix_a  (sa_matrix_a),
      .sa_matrix_b  (sa_matrix_b),
      .sa_valid_out (sa_valid_out),
      .sa_matrix_c  (sa_matrix_c),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_row      (out_row),
      .out_last     (out_last),
      .busy         (busy),
      .done         (done),
      .err          (err)
   );

   //---------------------------------------------------------------------------
   // Array stub: outer-product accumulator, cleared by sa_rst_n
   //---------------------------------------------------------------------------
   int acc [N][N];
   int st_feeds = 0;
   int st_wait  = 0;
   int st_row   = 0;
   bit st_emit  = 1'b0;

   always @(negedge clk) begin
      sa_valid_out = 1'b0;
      sa_matrix_c  = '0;
      if (!sa_rst_n) begin
         for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
               acc[i][j] = 0;
         st_feeds = 0;
         st_emit  = 1'b0;
      end else if (sa_valid_in) begin
         for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
               int pa, pb;
               pa = int'($signed(sa_matrix_a[i*DW +: DW]));
               pb = int'($signed(sa_matrix_b[j*DW +: DW]));
               acc[i][j] = acc[i][j] + pa * pb;
            end
         end
         st_feeds++;
         if (st_feeds == N) begin
            st_emit = 1'b1;
            st_row  = 0;
            st_wait = int'($urandom_range(0, 3));
         end
      end else if (st_emit && !stub_mute) begin
         if (st_wait > 0) begin
            st_wait--;
         end else if ($urandom_range(0, 3) != 0) begin
            sa_valid_out = 1'b1;
            for (int j = 0; j < N; j++)
               sa_matrix_c[j*2*DW +: 2*DW] = acc[st_row][j][2*DW-1:0];
            st_row++;
            if (st_row == N) st_emit = 1'b0;
         end
      end else if (stub_noise && (!busy || out_valid)) begin
         // Stray valid_out while the controller is not collecting results.
         if ($urandom_range(0, 2) == 0) begin
            sa_valid_out = 1'b1;
            sa_matrix_c  = {$urandom, $urandom, $urandom};
         end
      end
   end

   //---------------------------------------------------------------------------
   // Reference model helpers
   //---------------------------------------------------------------------------
   function automatic void matmul(input mat_t a, input mat_t b, output mat_t c);
      for (int i = 0; i < N; i++) begin
         for (int j = 0; j < N; j++) begin
            c[i][j] = 0;
            for (int k = 0; k < N; k++) c[i][j] += a[i][k] * b[k][j];
         end
      end
   endfunction

   function automatic logic [AW-1:0] pack_row(input mat_t m, input int i);
      logic [AW-1:0] r;
      for (int j = 0; j < N; j++) r[j*DW +: DW] = m[i][j][DW-1:0];
      return r;
   endfunction

   function automatic logic [AW-1:0] pack_col(input mat_t m, input int k);
      logic [AW-1:0] r;
      for (int i = 0; i < N; i++) r[i*DW +: DW] = m[i][k][DW-1:0];
      return r;
   endfunction

   function automatic logic [CW-1:0] pack_c(input mat_t m, input int i);
      logic [CW-1:0] r;
      for (int j = 0; j < N; j++) r[j*2*DW +: 2*DW] = m[i][j][2*DW-1:0];
      return r;
   endfunction

   function automatic void rand_mat(output mat_t m, input int lim);
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++)
            m[i][j] = int'($urandom_range(0, 2 * lim)) - lim;
   endfunction

   //---------------------------------------------------------------------------
   // Stimulus tasks (all start and end on a falling edge)
   //---------------------------------------------------------------------------
   task automatic load_job(input mat_t a, input mat_t b, input bit gaps);
      for (int i = 0; i < N; i++) begin
         if (gaps) begin
            repeat ($urandom_range(0, 1)) begin
               in_valid = 1'b0;
               in_a_row = AW'({$urandom, $urandom});
               in_b_row = AW'({$urandom, $urandom});
               @(negedge clk);
            end
         end
         in_valid = 1'b1;
         in_a_row = pack_row(a, i);
         in_b_row = pack_row(b, i);
         n_checks++;
         if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL load_ready beat=%0d got=%b want=1", i, in_ready);
         end
         @(negedge clk);
         in_valid = 1'b0;
         if (i == 0) begin
            n_checks++;
            if (err !== 1'b0) begin
               n_fail++;
               $display("FAIL err_clear_on_beat got=%b want=0", err);
            end
         end
      end
   endtask

   // ready_mode: 0 = always ready, 1 = toggle every 2 cycles, 2 = random
   task automatic run_job(input mat_t a, input mat_t b, input int ready_mode,
                          input bit hold_valid, input bit gaps, input string name);
      mat_t          c_exp;
      int            rows, clr_cnt, feed_cnt;
      bit            fin, prev_stall, rdy;
      logic [CW-1:0] prev_row;

      matmul(a, b, c_exp);
      out_ready = 1'b1;
      load_job(a, b, gaps);
      rows = 0; clr_cnt = 0; feed_cnt = 0;
      fin = 1'b0; prev_stall = 1'b0; prev_row = '0;

      for (int cyc = 0; cyc < 300 && !fin; cyc++) begin
         if (done) begin
            fin = 1'b1;
            n_checks++;
            if (rows != N || out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
               n_fail++;
               $display("FAIL %s done_state rows=%0d out_valid=%b busy=%b in_ready=%b want rows=%0d 0 0 1",
                        name, rows, out_valid, busy, in_ready, N);
            end
         end else begin
            n_checks++;
            if (busy !== 1'b1 || in_ready !== 1'b0) begin
               n_fail++;
               $display("FAIL %s busy_flags cyc=%0d busy=%b in_ready=%b want 1 0",
                        name, cyc, busy, in_ready);
            end
            if (!sa_rst_n)  clr_cnt++;
            if (sa_valid_in) feed_cnt++;
            if (out_valid) begin
               if (prev_stall) begin
                  n_checks++;
                  if (out_row !== prev_row) begin
                     n_fail++;
                     $display("FAIL %s stall_hold got=%h want=%h", name, out_row, prev_row);
                  end
               end
               n_checks++;
               if (out_last !== (rows == N - 1)) begin
                  n_fail++;
                  $display("FAIL %s out_last row=%0d got=%b want=%b",
                           name, rows, out_last, (rows == N - 1));
               end
            end else if (prev_stall) begin
               n_checks++;
               n_fail++;
               $display("FAIL %s stall_valid_dropped got=0 want=1", name);
            end
            case (ready_mode)
               0:       rdy = 1'b1;
               1:       rdy = ((cyc / 2) % 2) == 1;
               default: rdy = 1'($urandom_range(0, 1));
            endcase
            out_ready = rdy;
            if (hold_valid) begin
               in_valid = 1'b1;
               in_a_row = AW'({$urandom, $urandom});
               in_b_row = AW'({$urandom, $urandom});
            end
            if (out_valid && rdy) begin
               n_checks++;
               if (rows >= N) begin
                  n_fail++;
                  $display("FAIL %s extra_row got=%0d rows want=%0d", name, rows + 1, N);
               end else if (out_row !== pack_c(c_exp, rows)) begin
                  n_fail++;
                  $display("FAIL %s row%0d got=%h want=%h", name, rows, out_row, pack_c(c_exp, rows));
               end
               rows++;
            end
            prev_stall = out_valid && !rdy;
            prev_row   = out_row;
            @(negedge clk);
         end
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;

      n_checks++;
      if (!fin) begin
         n_fail++;
         $display("FAIL %s no_done_within_budget rows=%0d want done", name, rows);
      end
      n_checks++;
      if (clr_cnt != 1) begin
         n_fail++;
         $display("FAIL %s clr_pulse got=%0d want=1", name, clr_cnt);
      end
      n_checks++;
      if (feed_cnt != N) begin
         n_fail++;
         $display("FAIL %s feed_cycles got=%0d want=%0d", name, feed_cnt, N);
      end
      @(negedge clk);
      n_checks++;
      if (done !== 1'b0) begin
         n_fail++;
         $display("FAIL %s done_width got=%b want=0", name, done);
      end
   endtask

   //---------------------------------------------------------------------------
   // Scenarios
   //---------------------------------------------------------------------------
   mat_t m_a1 = '{'{1, 2, 3}, '{4, 5, 6}, '{7, 8, 9}};
   mat_t m_b1 = '{'{9, 8, 7}, '{6, 5, 4}, '{3, 2, 1}};
   mat_t m_a2 = '{'{2, 3, 4}, '{5, 6, 7}, '{8, 9, 10}};
   mat_t m_b2 = '{'{1, 2, 3}, '{4, 5, 6}, '{7, 8, 9}};

   task automatic check_reset_outputs(input string name);
      n_checks++;
      if ({in_ready, sa_rst_n, sa_valid_in, out_valid, out_last, busy, done, err} !== 8'b1100_0000
          || sa_matrix_a !== '0 || sa_matrix_b !== '0) begin
         n_fail++;
         $display("FAIL %s flags got=%b want=11000000 sa_a=%h sa_b=%h want 0",
                  name, {in_ready, sa_rst_n, sa_valid_in, out_valid, out_last, busy, done, err},
                  sa_matrix_a, sa_matrix_b);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      check_reset_outputs("reset");
   endtask

   task automatic test_basic();
      run_job(m_a1, m_b1, 0, 1'b0, 1'b0, "basic");
   endtask

   task automatic test_back_to_back();
      run_job(m_a2, m_b2, 0, 1'b0, 1'b0, "back_to_back");
   endtask

   task automatic test_stall();
      run_job(m_a1, m_b1, 1, 1'b0, 1'b0, "stall");
   endtask

   task automatic test_timeout();
      int wait_entry, err_cyc;
      bit prev_sv, saw_ov;
      stub_mute = 1'b1;
      load_job(m_a1, m_b1, 1'b0);
      wait_entry = -1; err_cyc = -1; prev_sv = 1'b0; saw_ov = 1'b0;
      for (int cyc = 0; cyc < 200 && err_cyc < 0; cyc++) begin
         if (out_valid) saw_ov = 1'b1;
         if (wait_entry < 0 && prev_sv && !sa_valid_in) wait_entry = cyc;
         if (err) begin
            err_cyc = cyc;
         end else begin
            prev_sv = sa_valid_in;
            @(negedge clk);
         end
      end
      n_checks++;
      if (err_cyc < 0 || wait_entry < 0 || (err_cyc - wait_entry) != TMO) begin
         n_fail++;
         $display("FAIL timeout_cycles got=%0d want=%0d", err_cyc - wait_entry, TMO);
      end
      n_checks++;
      if (saw_ov || in_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
         n_fail++;
         $display("FAIL timeout_state out_valid_seen=%b in_ready=%b busy=%b done=%b want 0 1 0 0",
                  saw_ov, in_ready, busy, done);
      end
      stub_mute = 1'b0;
      repeat (3) @(negedge clk);
      n_checks++;
      if (err !== 1'b1) begin
         n_fail++;
         $display("FAIL err_sticky got=%b want=1", err);
      end
      run_job(m_a2, m_b2, 0, 1'b0, 1'b0, "after_timeout");
   endtask

   task automatic test_rst_feed();
      load_job(m_a1, m_b1, 1'b0);
      n_checks++;
      if (sa_rst_n !== 1'b0) begin
         n_fail++;
         $display("FAIL clr_state sa_rst_n got=%b want=0", sa_rst_n);
      end
      @(negedge clk);
      @(negedge clk);
      n_checks++;
      if (sa_valid_in !== 1'b1 || sa_matrix_a !== pack_col(m_a1, 1) || sa_matrix_b !== pack_row(m_b1, 1)) begin
         n_fail++;
         $display("FAIL feed_k1 valid=%b a=%h b=%h want 1 %h %h",
                  sa_valid_in, sa_matrix_a, sa_matrix_b, pack_col(m_a1, 1), pack_row(m_b1, 1));
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_reset_outputs("rst_mid_feed");
      run_job(m_a2, m_b1, 0, 1'b0, 1'b0, "after_rst");
   endtask

   task automatic test_hold_valid();
      mat_t a, b;
      rand_mat(a, 300);
      rand_mat(b, 300);
      run_job(a, b, 2, 1'b1, 1'b0, "hold_valid");
   endtask

   task automatic test_random();
      mat_t a, b;
      for (int t = 0; t < 6; t++) begin
         rand_mat(a, 2000);
         rand_mat(b, 2000);
         run_job(a, b, 2, 1'b0, 1'b1, "random");
      end
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_a_row  = '0;
      in_b_row  = '0;
      out_ready = 1'b1;
      @(negedge clk);
      test_reset();
      test_basic();
      test_back_to_back();
      test_stall();
      test_timeout();
      test_rst_feed();
      test_hold_valid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog expired");
   end

endmodule
